// File: rtl/id_stage_pkg.sv
// Shared constants for the instruction decode / operand-issue stage.
package id_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // Shift immediates carry a meaningful funct7 (SRAI sets bit 30).
    function automatic logic isShiftFunct3(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Architectural register file: two asynchronous read ports and one
// synchronous write port. x0 reads as zero and ignores writes; indices
// at or above NREG are ignored on write and read back as zero.
module id_stage_regfile
    import id_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREG];

    logic writeOk;
    assign writeOk = we_i && (waddr_i != 5'd0) && (32'(waddr_i) < NREG);

    // Storage update: clear everything on reset, otherwise commit writebacks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeOk) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read ports with x0 and out-of-range forced to zero.
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if ((raddr1_i != 5'd0) && (32'(raddr1_i) < NREG)) begin
            rdata1_o = regs_q[raddr1_i];
        end
        if ((raddr2_i != 5'd0) && (32'(raddr2_i) < NREG)) begin
            rdata2_o = regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode / operand-issue stage. Splits an RV32I word, reads
// operands with writeback bypass, stalls on scoreboard hazards and issues
// through a single output register with valid/ready back-pressure.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd_addr,
    output logic            out_illegal
);

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rdAddr;
    logic [2:0] funct3;
    logic [4:0] rs1Addr;
    logic [4:0] rs2Addr;
    logic [6:0] funct7;

    assign opcode  = in_inst[6:0];
    assign rdAddr  = in_inst[11:7];
    assign funct3  = in_inst[14:12];
    assign rs1Addr = in_inst[19:15];
    assign rs2Addr = in_inst[24:20];
    assign funct7  = in_inst[31:25];

    logic isOp;
    logic isOpImm;
    logic illegal;

    assign isOp    = (opcode == OPC_OP);
    assign isOpImm = (opcode == OPC_OP_IMM);
    assign illegal = !(isOp || isOpImm);

    // Register file and bypass
    logic [XLEN-1:0] rfRs1;
    logic [XLEN-1:0] rfRs2;

    id_stage_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk_i    (clk),
        .rst_ni   (rst),
        .raddr1_i (rs1Addr),
        .rdata1_o (rfRs1),
        .raddr2_i (rs2Addr),
        .rdata2_o (rfRs2),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    logic wbValidReg;
    logic wbHitsRs1;
    logic wbHitsRs2;

    assign wbValidReg = wb_en && (wb_addr != 5'd0) && (32'(wb_addr) < NREG);
    assign wbHitsRs1  = wbValidReg && (wb_addr == rs1Addr);
    assign wbHitsRs2  = wbValidReg && (wb_addr == rs2Addr);

    logic [XLEN-1:0] rs1Val;
    logic [XLEN-1:0] rs2Val;
    logic [XLEN-1:0] immVal;

    assign rs1Val = wbHitsRs1 ? wb_data : rfRs1;
    assign rs2Val = wbHitsRs2 ? wb_data : rfRs2;
    assign immVal = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};

    // Scoreboard, widened to 32 bits so any 5-bit index is a legal select
    logic [NREG-1:0] scoreboard_q;
    logic [NREG-1:0] scoreboard_d;
    logic [31:0]     sbWide;

    assign sbWide = 32'(scoreboard_q);

    logic rs1Busy;
    logic rs2Busy;
    logic hazard;

    assign rs1Busy = (rs1Addr != 5'd0) && sbWide[rs1Addr] && !wbHitsRs1;
    assign rs2Busy = isOp && (rs2Addr != 5'd0) && sbWide[rs2Addr] && !wbHitsRs2;
    assign hazard  = !illegal && (rs1Busy || rs2Busy);

    logic outValid_q;
    logic accept;

    assign in_ready = !hazard && (!outValid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Output register state
    logic            outValid_d;
    logic [XLEN-1:0] outRs1_q,     outRs1_d;
    logic [XLEN-1:0] outRs2_q,     outRs2_d;
    logic [6:0]      outOpcode_q,  outOpcode_d;
    logic [2:0]      outFunct3_q,  outFunct3_d;
    logic [6:0]      outFunct7_q,  outFunct7_d;
    logic [4:0]      outRd_q,      outRd_d;
    logic            outIllegal_q, outIllegal_d;

    // Next-state for the issue register: load on accept, drain on consume, else hold.
    always_comb begin
        outValid_d   = outValid_q;
        outRs1_d     = outRs1_q;
        outRs2_d     = outRs2_q;
        outOpcode_d  = outOpcode_q;
        outFunct3_d  = outFunct3_q;
        outFunct7_d  = outFunct7_q;
        outRd_d      = outRd_q;
        outIllegal_d = outIllegal_q;
        if (accept) begin
            outValid_d   = 1'b1;
            outRs1_d     = rs1Val;
            outRs2_d     = isOpImm ? immVal : rs2Val;
            outOpcode_d  = opcode;
            outFunct3_d  = funct3;
            outFunct7_d  = (isOpImm && !isShiftFunct3(funct3)) ? 7'd0 : funct7;
            outRd_d      = rdAddr;
            outIllegal_d = illegal;
        end else if (out_ready) begin
            outValid_d   = 1'b0;
        end
    end

    // Next-state for the scoreboard: writeback clears, then a new producer sets.
    always_comb begin
        logic [31:0] sbNext;
        sbNext = sbWide;
        if (wb_en) begin
            sbNext[wb_addr] = 1'b0;
        end
        if (accept && !illegal && (rdAddr != 5'd0)) begin
            sbNext[rdAddr] = 1'b1;
        end
        sbNext[0]    = 1'b0;
        scoreboard_d = sbNext[NREG-1:0];
    end

    // State registers for the issue slot and scoreboard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outValid_q   <= 1'b0;
            outRs1_q     <= '0;
            outRs2_q     <= '0;
            outOpcode_q  <= '0;
            outFunct3_q  <= '0;
            outFunct7_q  <= '0;
            outRd_q      <= '0;
            outIllegal_q <= 1'b0;
            scoreboard_q <= '0;
        end else begin
            outValid_q   <= outValid_d;
            outRs1_q     <= outRs1_d;
            outRs2_q     <= outRs2_d;
            outOpcode_q  <= outOpcode_d;
            outFunct3_q  <= outFunct3_d;
            outFunct7_q  <= outFunct7_d;
            outRd_q      <= outRd_d;
            outIllegal_q <= outIllegal_d;
            scoreboard_q <= scoreboard_d;
        end
    end

    assign out_valid   = outValid_q;
    assign out_rs1     = outRs1_q;
    assign out_rs2     = outRs2_q;
    assign out_opcode  = outOpcode_q;
    assign out_funct3  = outFunct3_q;
    assign out_funct7  = outFunct7_q;
    assign out_rd_addr = outRd_q;
    assign out_illegal = outIllegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: operand read, immediates, hazard stall
// with bypass release, back-pressure, async reset, illegal ops and x0.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd_addr;
    logic        out_illegal;

    int vectorCount = 0;
    int missCount   = 0;

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rd_addr (out_rd_addr),
        .out_illegal (out_illegal)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                                 input logic wbEn, input logic [4:0] wbAddr,
                                 input logic [31:0] wbData, input logic outReady);
        in_valid  = valid;
        in_inst   = inst;
        wb_en     = wbEn;
        wb_addr   = wbAddr;
        wb_data   = wbData;
        out_ready = outReady;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD_X3   = 32'h002081B3;
    localparam logic [31:0] ADDI_X4  = 32'hFFF00213;
    localparam logic [31:0] SRAI_X5  = 32'h40325293;
    localparam logic [31:0] SUB_X6   = 32'h40118333;
    localparam logic [31:0] ADDI_X7  = 32'h07F00393;
    localparam logic [31:0] ADD_X8   = 32'h00530433;
    localparam logic [31:0] LW_X10   = 32'h00042503;
    localparam logic [31:0] ADD_X11  = 32'h000505B3;
    localparam logic [31:0] ADD_X12  = 32'h00000633;

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // Reset state
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_rs1",   out_rs1,        32'd0);
        checkOutput("rst_out_rd",    32'(out_rd_addr), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        step();
        step();
        rst = 1'b1;

        // Load x1=5, x2=3 through writeback
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd1, 32'd5, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd2, 32'd3, 1'b1);
        step();

        // add x3,x1,x2
        applyStimulus(1'b1, ADD_X3, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("add_in_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("add_valid",   32'(out_valid),   32'd1);
        checkOutput("add_rs1",     out_rs1,          32'd5);
        checkOutput("add_rs2",     out_rs2,          32'd3);
        checkOutput("add_opcode",  32'(out_opcode),  32'h33);
        checkOutput("add_funct3",  32'(out_funct3),  32'd0);
        checkOutput("add_rd",      32'(out_rd_addr), 32'd3);
        checkOutput("add_illegal", 32'(out_illegal), 32'd0);

        // addi x4,x0,-1
        applyStimulus(1'b1, ADDI_X4, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("addi_in_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("addi_rs1",    out_rs1,          32'd0);
        checkOutput("addi_rs2",    out_rs2,          32'hFFFFFFFF);
        checkOutput("addi_funct7", 32'(out_funct7),  32'd0);
        checkOutput("addi_opcode", 32'(out_opcode),  32'h13);
        checkOutput("addi_rd",     32'(out_rd_addr), 32'd4);

        // srai x5,x4,3 while x4 is written back in the same cycle
        applyStimulus(1'b1, SRAI_X5, 1'b1, 5'd4, 32'hFFFFFFFF, 1'b1);
        checkOutput("srai_in_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("srai_rs1",    out_rs1,          32'hFFFFFFFF);
        checkOutput("srai_rs2",    out_rs2,          32'h00000403);
        checkOutput("srai_funct7", 32'(out_funct7),  32'h20);
        checkOutput("srai_funct3", 32'(out_funct3),  32'd5);
        checkOutput("srai_rd",     32'(out_rd_addr), 32'd5);

        // sub x6,x3,x1 stalls on pending x3
        applyStimulus(1'b1, SUB_X6, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("sub_stall_ready0", 32'(in_ready), 32'd0);
        step();
        checkOutput("sub_stall_ready1", 32'(in_ready),  32'd0);
        checkOutput("sub_stall_valid",  32'(out_valid), 32'd0);
        applyStimulus(1'b1, SUB_X6, 1'b1, 5'd3, 32'h10, 1'b1);
        checkOutput("sub_wb_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("sub_valid",  32'(out_valid),   32'd1);
        checkOutput("sub_rs1",    out_rs1,          32'h10);
        checkOutput("sub_rs2",    out_rs2,          32'd5);
        checkOutput("sub_funct7", 32'(out_funct7),  32'h20);
        checkOutput("sub_rd",     32'(out_rd_addr), 32'd6);

        // Back-pressure: sub is held while addi x7 waits
        applyStimulus(1'b1, ADDI_X7, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("bp_ready_pre", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("bp_valid", 32'(out_valid),   32'd1);
            checkOutput("bp_rd",    32'(out_rd_addr), 32'd6);
            checkOutput("bp_rs1",   out_rs1,          32'h10);
            checkOutput("bp_ready", 32'(in_ready),    32'd0);
        end
        applyStimulus(1'b1, ADDI_X7, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("addi7_rd",  32'(out_rd_addr), 32'd7);
        checkOutput("addi7_rs2", out_rs2,          32'h7F);
        checkOutput("addi7_rs1", out_rs1,          32'd0);

        // Async reset during a stalled, back-pressured transfer
        applyStimulus(1'b1, ADD_X8, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("pre_rst_ready", 32'(in_ready), 32'd0);
        step();
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid),   32'd0);
        checkOutput("async_rst_rd",    32'(out_rd_addr), 32'd0);
        checkOutput("async_rst_rs2",   out_rs2,          32'd0);
        step();
        rst = 1'b1;
        applyStimulus(1'b1, ADD_X8, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("post_rst_valid", 32'(out_valid),   32'd1);
        checkOutput("post_rst_rd",    32'(out_rd_addr), 32'd8);
        checkOutput("post_rst_rs1",   out_rs1,          32'd0);

        // Illegal opcode ignores pending x8 and does not mark x10
        applyStimulus(1'b1, LW_X10, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("ill_in_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("ill_flag",   32'(out_illegal), 32'd1);
        checkOutput("ill_opcode", 32'(out_opcode),  32'h03);
        checkOutput("ill_funct3", 32'(out_funct3),  32'd2);
        checkOutput("ill_rd",     32'(out_rd_addr), 32'd10);
        applyStimulus(1'b1, ADD_X11, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("after_ill_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("after_ill_flag", 32'(out_illegal), 32'd0);
        checkOutput("after_ill_rd",   32'(out_rd_addr), 32'd11);

        // Writes to x0 are dropped, both bypassed and stored
        applyStimulus(1'b1, ADD_X12, 1'b1, 5'd0, 32'h0000DEAD, 1'b1);
        checkOutput("x0_in_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("x0_bypass_rs1", out_rs1,          32'd0);
        checkOutput("x0_bypass_rs2", out_rs2,          32'd0);
        checkOutput("x0_rd",         32'(out_rd_addr), 32'd12);
        applyStimulus(1'b1, ADD_X12, 1'b0, 5'd0, 32'h0, 1'b1);
        step();
        checkOutput("x0_stored_rs1", out_rs1, 32'd0);
        checkOutput("x0_stored_rs2", out_rs2, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        step();
        checkOutput("drain_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
